// File: rtl/llc_mem_port_pkg.sv
// Shared types and constants for the LLC memory-side port.
package llc_mem_port_pkg;

  localparam int unsigned ADDR_SIZE   = 32;
  localparam int unsigned CACHE_LINE  = 64;
  localparam int unsigned BEAT_BYTES  = 8;
  localparam int unsigned BEATS       = CACHE_LINE / BEAT_BYTES;
  localparam int unsigned BYTE_SELECT = $clog2(CACHE_LINE);
  localparam int unsigned BEAT_W      = $clog2(BEATS);

  localparam logic DATA_READ  = 1'b0;
  localparam logic DATA_WRITE = 1'b1;

  typedef logic [CACHE_LINE*8-1:0] line_t;
  typedef logic [BEAT_BYTES*8-1:0] beat_t;
  typedef logic [ADDR_SIZE-1:0]    addr_t;
  typedef beat_t [BEATS-1:0]       line_beats_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    RESP
  } mem_state_t;

  function automatic addr_t line_align(input addr_t a);
    addr_t mask;
    mask = '1;
    mask[BYTE_SELECT-1:0] = '0;
    return a & mask;
  endfunction

endpackage

// File: rtl/llc_mem_port_if.sv
// LLC request/response bus and beat-serial memory bus.
interface llc_req_if;
  import llc_mem_port_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_op;
  addr_t req_addr;
  line_t req_wline;
  logic  rsp_valid;
  logic  rsp_op;
  line_t rsp_rline;

  modport master (
    output req_valid, req_op, req_addr, req_wline,
    input  req_ready, rsp_valid, rsp_op, rsp_rline
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wline,
    output req_ready, rsp_valid, rsp_op, rsp_rline
  );
endinterface

interface mem_bus_if;
  import llc_mem_port_pkg::*;

  logic  mem_cmd_valid;
  logic  mem_cmd_ready;
  logic  mem_cmd_write;
  addr_t mem_cmd_addr;
  logic  mem_wvalid;
  logic  mem_wready;
  beat_t mem_wdata;
  logic  mem_rvalid;
  beat_t mem_rdata;

  modport master (
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wvalid, mem_wdata,
    input  mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wvalid, mem_wdata,
    output mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/llc_mem_port.sv
// Memory-side port of the LLC: runs one line fill or writeback at a time
// over a beat-serial memory bus and returns a single response pulse.
module llc_mem_port
  import llc_mem_port_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  llc_req_if.slave   llc,
  mem_bus_if.master  mem,
  output logic [7:0] stray_beats
);

  mem_state_t        state, state_nxt;
  logic              op_q;
  addr_t             addr_q;
  line_beats_t       wline_q;
  line_beats_t       rline_q;
  logic [BEAT_W-1:0] beat_q;
  logic              last_beat;
  logic              accept;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign accept    = (state == IDLE) && llc.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (llc.req_valid) state_nxt = CMD;
      CMD:     if (mem.mem_cmd_ready)
                 state_nxt = (op_q == DATA_WRITE) ? WDATA : RDATA;
      WDATA:   if (mem.mem_wready && last_beat) state_nxt = RESP;
      RDATA:   if (mem.mem_rvalid && last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it reads 0 while reset is held, not just after.
  assign llc.req_ready = rst_n && (state == IDLE);
  assign llc.rsp_valid = (state == RESP);
  assign llc.rsp_op    = op_q;
  assign llc.rsp_rline = rline_q;

  assign mem.mem_cmd_valid = (state == CMD);
  assign mem.mem_cmd_write = op_q;
  assign mem.mem_cmd_addr  = addr_q;
  assign mem.mem_wvalid    = (state == WDATA);
  assign mem.mem_wdata     = wline_q[beat_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= DATA_READ;
      addr_q  <= '0;
      wline_q <= '0;
    end else if (accept) begin
      op_q   <= llc.req_op;
      addr_q <= line_align(llc.req_addr);
      if (llc.req_op == DATA_WRITE) wline_q <= llc.req_wline;
    end
  end

  // rline_q is only written by fills, so a writeback leaves the last fill intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      rline_q <= '0;
    end else begin
      unique case (state)
        CMD:     if (mem.mem_cmd_ready) beat_q <= '0;
        WDATA:   if (mem.mem_wready) beat_q <= beat_q + 1'b1;
        RDATA:   if (mem.mem_rvalid) begin
                   rline_q[beat_q] <= mem.mem_rdata;
                   beat_q          <= beat_q + 1'b1;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stray_beats <= '0;
    else if (mem.mem_rvalid && (state != RDATA) && (stray_beats != 8'hFF))
      stray_beats <= stray_beats + 8'd1;
  end

endmodule

// File: tb/tb_llc_mem_port.sv
// Directed self-checking bench for llc_mem_port.
module tb_llc_mem_port;
  import llc_mem_port_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] stray_beats;
  int         checks;
  int         failures;

  llc_req_if llc ();
  mem_bus_if mem ();

  llc_mem_port dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .llc         (llc),
    .mem         (mem),
    .stray_beats (stray_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  line_t exp_line;
  line_t wl;
  beat_t bt;
  int    seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    llc.req_valid = 1'b0;
    llc.req_op    = 1'b0;
    llc.req_addr  = '0;
    llc.req_wline = '0;
    mem.mem_cmd_ready = 1'b1;
    mem.mem_wready    = 1'b1;
    mem.mem_rvalid    = 1'b0;
    mem.mem_rdata     = '0;

    // reset state
    step(); step();
    chk("rst_req_ready", 512'(llc.req_ready), 512'(0));
    chk("rst_rsp_valid", 512'(llc.rsp_valid), 512'(0));
    chk("rst_cmd_valid", 512'(mem.mem_cmd_valid), 512'(0));
    chk("rst_stray", 512'(stray_beats), 512'(0));
    chk("rst_rline", 512'(llc.rsp_rline), 512'(0));
    rst_n = 1'b1;
    step();
    chk("idle_req_ready", 512'(llc.req_ready), 512'(1));

    // read, no stalls
    llc.req_valid = 1'b1; llc.req_op = 1'b0; llc.req_addr = 32'h0001_23C5;
    step();
    llc.req_valid = 1'b0;
    chk("rd_cmd_valid", 512'(mem.mem_cmd_valid), 512'(1));
    chk("rd_cmd_addr", 512'(mem.mem_cmd_addr), 512'(32'h0001_23C0));
    chk("rd_cmd_write", 512'(mem.mem_cmd_write), 512'(0));
    chk("rd_req_ready", 512'(llc.req_ready), 512'(0));
    step();
    for (int i = 0; i < 8; i++) begin
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata  = {8{8'(i)}};
      exp_line[i*64 +: 64] = {8{8'(i)}};
      chk("rd_rsp_early", 512'(llc.rsp_valid), 512'(0));
      step();
    end
    mem.mem_rvalid = 1'b0;
    chk("rd_rsp_valid", 512'(llc.rsp_valid), 512'(1));
    chk("rd_rsp_op", 512'(llc.rsp_op), 512'(0));
    chk("rd_rline", 512'(llc.rsp_rline), 512'(exp_line));
    step();
    chk("rd_rsp_pulse", 512'(llc.rsp_valid), 512'(0));
    chk("rd_req_ready_back", 512'(llc.req_ready), 512'(1));

    // write, wready toggling 1/0
    for (int b = 0; b < 64; b++) wl[b*8 +: 8] = 8'(b);
    llc.req_valid = 1'b1; llc.req_op = 1'b1; llc.req_addr = 32'h8000_0047; llc.req_wline = wl;
    step();
    llc.req_valid = 1'b0;
    chk("wr_cmd_write", 512'(mem.mem_cmd_write), 512'(1));
    chk("wr_cmd_addr", 512'(mem.mem_cmd_addr), 512'(32'h8000_0040));
    step();
    chk("wr_beat0", 512'(mem.mem_wdata), 512'(64'h0706_0504_0302_0100));
    for (int c = 0; c < 15; c++) begin
      mem.mem_wready = (c % 2 == 0);
      chk("wr_wvalid", 512'(mem.mem_wvalid), 512'(1));
      chk("wr_rsp_early", 512'(llc.rsp_valid), 512'(0));
      if (mem.mem_wready) chk("wr_wdata", 512'(mem.mem_wdata), 512'(wl[(c/2)*64 +: 64]));
      step();
    end
    mem.mem_wready = 1'b1;
    chk("wr_rsp_valid", 512'(llc.rsp_valid), 512'(1));
    chk("wr_rsp_op", 512'(llc.rsp_op), 512'(1));
    chk("wr_wvalid_done", 512'(mem.mem_wvalid), 512'(0));
    step();
    chk("wr_rsp_pulse", 512'(llc.rsp_valid), 512'(0));

    // command stalled for 5 cycles
    mem.mem_cmd_ready = 1'b0;
    llc.req_valid = 1'b1; llc.req_op = 1'b0; llc.req_addr = 32'hFFFF_FFFF;
    step();
    llc.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("st_cmd_valid", 512'(mem.mem_cmd_valid), 512'(1));
      chk("st_cmd_addr", 512'(mem.mem_cmd_addr), 512'(32'hFFFF_FFC0));
      chk("st_cmd_write", 512'(mem.mem_cmd_write), 512'(0));
      chk("st_req_ready", 512'(llc.req_ready), 512'(0));
      step();
    end
    mem.mem_cmd_ready = 1'b1;
    chk("st_cmd_hs", 512'(mem.mem_cmd_valid), 512'(1));
    step();
    for (int i = 0; i < 8; i++) begin
      mem.mem_rvalid = 1'b1;
      bt = {32'hDEAD_0000 | 32'(i), 32'h1234_5678 ^ 32'(i)};
      mem.mem_rdata = bt;
      exp_line[i*64 +: 64] = bt;
      chk("st_rsp_early", 512'(llc.rsp_valid), 512'(0));
      chk("st_req_ready_busy", 512'(llc.req_ready), 512'(0));
      step();
    end
    mem.mem_rvalid = 1'b0;
    chk("st_rsp_valid", 512'(llc.rsp_valid), 512'(1));
    chk("st_rline", 512'(llc.rsp_rline), 512'(exp_line));
    step();

    // stray beats while idle
    for (int n = 0; n < 254; n++) begin
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      step();
    end
    chk("stray_254", 512'(stray_beats), 512'(254));
    for (int n = 0; n < 46; n++) step();
    mem.mem_rvalid = 1'b0;
    chk("stray_sat", 512'(stray_beats), 512'(255));
    chk("stray_no_rsp", 512'(llc.rsp_valid), 512'(0));
    chk("stray_idle", 512'(llc.req_ready), 512'(1));
    chk("stray_rline_kept", 512'(llc.rsp_rline), 512'(exp_line));

    // reset during beat 4 of a read
    llc.req_valid = 1'b1; llc.req_op = 1'b0; llc.req_addr = 32'h0000_0040;
    step();
    llc.req_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata  = {8{8'(i + 16)}};
      step();
    end
    mem.mem_rdata = {8{8'h14}};
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 512'(llc.req_ready), 512'(0));
    chk("mr_rsp_valid", 512'(llc.rsp_valid), 512'(0));
    chk("mr_rsp_op", 512'(llc.rsp_op), 512'(0));
    chk("mr_rline", 512'(llc.rsp_rline), 512'(0));
    chk("mr_cmd_valid", 512'(mem.mem_cmd_valid), 512'(0));
    chk("mr_cmd_write", 512'(mem.mem_cmd_write), 512'(0));
    chk("mr_cmd_addr", 512'(mem.mem_cmd_addr), 512'(0));
    chk("mr_wvalid", 512'(mem.mem_wvalid), 512'(0));
    chk("mr_wdata", 512'(mem.mem_wdata), 512'(0));
    chk("mr_stray", 512'(stray_beats), 512'(0));
    mem.mem_rvalid = 1'b0;
    step();
    chk("mr_hold_rsp", 512'(llc.rsp_valid), 512'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("mr_post_ready", 512'(llc.req_ready), 512'(1));
    chk("mr_post_cmd", 512'(mem.mem_cmd_valid), 512'(0));
    chk("mr_post_rsp", 512'(llc.rsp_valid), 512'(0));

    // write after reset, no stalls
    for (int b = 0; b < 64; b++) wl[b*8 +: 8] = 8'(255 - b);
    llc.req_valid = 1'b1; llc.req_op = 1'b1; llc.req_addr = 32'h0000_1000; llc.req_wline = wl;
    step();
    llc.req_valid = 1'b0;
    chk("pw_cmd_valid", 512'(mem.mem_cmd_valid), 512'(1));
    chk("pw_cmd_write", 512'(mem.mem_cmd_write), 512'(1));
    step();
    for (int c = 0; c < 8; c++) begin
      chk("pw_wvalid", 512'(mem.mem_wvalid), 512'(1));
      chk("pw_wdata", 512'(mem.mem_wdata), 512'(wl[c*64 +: 64]));
      step();
    end
    chk("pw_rsp_valid", 512'(llc.rsp_valid), 512'(1));
    chk("pw_rsp_op", 512'(llc.rsp_op), 512'(1));
    step();
    chk("pw_req_ready", 512'(llc.req_ready), 512'(1));

    // back-to-back with req_valid held high
    llc.req_valid = 1'b1; llc.req_op = 1'b1; llc.req_addr = 32'h0000_2000;
    step();
    for (int k = 0; k < 9; k++) begin
      chk("bb_busy_ready", 512'(llc.req_ready), 512'(0));
      step();
    end
    chk("bb_rsp_valid", 512'(llc.rsp_valid), 512'(1));
    chk("bb_rsp_ready", 512'(llc.req_ready), 512'(0));
    llc.req_addr = 32'h0000_3000;
    step();
    chk("bb_idle_ready", 512'(llc.req_ready), 512'(1));
    chk("bb_idle_cmd", 512'(mem.mem_cmd_valid), 512'(0));
    step();
    llc.req_valid = 1'b0;
    chk("bb_cmd2_valid", 512'(mem.mem_cmd_valid), 512'(1));
    chk("bb_cmd2_addr", 512'(mem.mem_cmd_addr), 512'(32'h0000_3000));
    seen = -1;
    for (int k = 0; k < 14; k++) begin
      if (llc.rsp_valid && seen < 0) seen = k;
      step();
    end
    chk("bb_rsp2_cycle", 512'(seen), 512'(9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llc_mem_port.md
# llc_mem_port

Memory-side port of the last-level cache. It accepts one line-granular request at a time from the LLC controller: either a fill read on a miss, or a writeback of a dirty victim. It runs the request over a beat-serial memory bus and returns one response per request. It sits between the LLC controller and the memory model, and is the lower-level end of the LLC's DATA_READ / DATA_WRITE traffic.

## Interface
- ADDR_SIZE, 32, address width
- CACHE_LINE, 64, line size in bytes
- BEAT_BYTES, 8, memory bus data width in bytes; BEATS = CACHE_LINE/BEAT_BYTES (8)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  LLC request present
- req_ready  out  1  port can accept a request
- req_op  in  1  DATA_READ (0) = fill, DATA_WRITE (1) = writeback
- req_addr  in  ADDR_SIZE  byte address; low BYTE_SELECT bits ignored
- req_wline  in  CACHE_LINE*8  writeback line data
- rsp_valid  out  1  one-cycle completion pulse (no backpressure)
- rsp_op  out  1  op of the completed request
- rsp_rline  out  CACHE_LINE*8  fill data, valid with rsp_valid on reads
- mem_cmd_valid  out  1  command to memory
- mem_cmd_ready  in  1  memory accepts command
- mem_cmd_write  out  1  1 = write command
- mem_cmd_addr  out  ADDR_SIZE  line-aligned address
- mem_wvalid  out  1  write beat present
- mem_wready  in  1  memory accepts write beat
- mem_wdata  out  BEAT_BYTES*8  write beat data
- mem_rvalid  in  1  read beat present (no backpressure)
- mem_rdata  in  BEAT_BYTES*8  read beat data
- stray_beats  out  8  saturating count of mem_rvalid cycles outside RDATA

## Operation
- FSM states: IDLE, CMD, WDATA, RDATA, RESP.
- IDLE: req_ready=1. When req_valid&req_ready:
  - latch op.
  - latch address with the low BYTE_SELECT bits forced to 0.
  - latch req_wline (writes only).
  - go to CMD.
- CMD: mem_cmd_valid=1, with addr/write held stable until mem_cmd_ready. On handshake: go to WDATA if write, else RDATA; clear the beat counter.
- WDATA: mem_wvalid=1, mem_wdata = line bytes [8i+7:8i] for beat i (ascending). The counter advances on mem_wvalid&mem_wready. On the handshake with counter == BEATS-1, go to RESP.
- RDATA: each mem_rvalid stores mem_rdata into rsp_rline[64i+:64] and advances the counter. On the beat with counter == BEATS-1, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_op = latched op, then IDLE.
- rsp_rline holds its last fill value until the next fill; on writes its value is don't-care.
- mem_rvalid in any state other than RDATA: data is dropped and stray_beats increments, saturating at 255.
- Beat counter width is $clog2(BEATS) and wraps to 0 after the last beat.

## Timing
- Reset (async assert, sync-released deassert):
  - state=IDLE.
  - all outputs 0, including req_ready while rst_n=0.
  - stray_beats=0 and rsp_rline=0.
- Reset mid-operation abandons the request: no rsp_valid, no further mem_* activity.
- Request accepted at cycle T → mem_cmd_valid from T+1.
- Write with zero stalls: cmd handshake at T+1, beats T+2..T+9, rsp_valid at T+10, req_ready at T+11.
- Read with zero stalls: cmd at T+1, rvalid beats T+2..T+9, rsp_valid at T+10.
- Each cycle of mem_cmd_ready=0, mem_wready=0, or a mem_rvalid gap delays completion by one cycle.
- req_ready=0 in every state except IDLE. There is no request pipelining: one outstanding request at a time.
- mem_wvalid is never deasserted mid-line once raised.

## Structure
- Shared package additions:
  - BEAT_BYTES, BEATS.
  - typedef logic [CACHE_LINE*8-1:0] line_t.
  - enum mem_state_t {IDLE, CMD, WDATA, RDATA, RESP}.
  - reuse DATA_READ / DATA_WRITE and BYTE_SELECT.
- Single module, no sub-modules. Line buffer, beat counter, FSM and stray counter are all inline.

## Test plan
- Read, addr 0x0001_23C5, memory returns beats 0x00..07 repeated per byte, no stalls → cmd_addr 0x0001_23C0, cmd_write 0, rsp_valid exactly at T+10, rsp_rline beat i = that pattern.
- Write, line bytes 0x00..0x3F, mem_wready toggling 1/0 → eight beats in ascending order (beat 0 = 0x0706050403020100), rsp_op 1, rsp_valid at T+17.
- mem_cmd_ready held 0 for 5 cycles → cmd_addr/write stable throughout, completion delayed by 5 cycles, req_ready stays 0.
- 300 mem_rvalid pulses while IDLE → stray_beats saturates at 255, no rsp_valid, no state change.
- rst_n low during beat 4 of a read → all outputs 0 immediately, no rsp_valid. After release, a new write completes normally.
- Back-to-back requests with req_valid held high → second accepted on the cycle after rsp_valid, never earlier.
